// File: rtl/priority_encoder.sv
// Registered highest-priority encoder: index, valid flag and (optionally) one-hot of the top set bit.
// Define PRIORITY_ENCODER_ONEHOT_EN to add the out_onehot port and its register.
module priority_encoder #(
    parameter int WIDTH = 8,
    parameter int OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [OUT_W-1:0] out,
    output logic             out_valid
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    ,
    output logic [WIDTH-1:0] out_onehot
`endif
);

    logic [OUT_W-1:0] idx;
    logic             any;
    logic [OUT_W-1:0] out_d, out_q;
    logic             out_valid_d, out_valid_q;

    // Ascending scan: the last set bit seen is the highest, so it wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in[i]) begin
                idx = OUT_W'(i);
                any = 1'b1;
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (en) begin
            out_d       = idx;
            out_valid_d = any;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

`ifdef PRIORITY_ENCODER_ONEHOT_EN
    logic [WIDTH-1:0] oh;
    logic [WIDTH-1:0] out_onehot_d, out_onehot_q;

    always_comb begin
        oh = '0;
        if (any) oh[idx] = 1'b1;
        out_onehot_d = en ? oh : out_onehot_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_onehot_q <= '0;
        else        out_onehot_q <= out_onehot_d;
    end

    assign out_onehot = out_onehot_q;
`endif

endmodule

// File: tb/tb_priority_encoder.sv
// Directed plus randomized checks of priority_encoder against an arithmetic reference model.
module tb_priority_encoder;

    localparam int WIDTH = 8;
    localparam int OUT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] in;
    logic [OUT_W-1:0] out;
    logic             out_valid;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    logic [WIDTH-1:0] out_onehot;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Expected register contents, maintained by the reference model.
    int exp_out   = 0;
    int exp_valid = 0;
    int exp_oh    = 0;

    priority_encoder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
`ifdef PRIORITY_ENCODER_ONEHOT_EN
        ,
        .out_onehot(out_onehot)
`endif
    );

    always #5 clk = ~clk;

    // floor(log2(v)) by halving; zero vector reports index 0, not valid.
    task automatic model(input int v);
        int t;
        int k;
        t = v;
        k = 0;
        while (t > 1) begin
            t = t / 2;
            k++;
        end
        exp_out   = k;
        exp_valid = (v != 0) ? 1 : 0;
        exp_oh    = (v != 0) ? (1 << k) : 0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out"}, int'(out), exp_out);
        chk({tag, ".valid"}, int'(out_valid), exp_valid);
`ifdef PRIORITY_ENCODER_ONEHOT_EN
        chk({tag, ".onehot"}, int'(out_onehot), exp_oh);
        chk({tag, ".inv"}, int'(out_onehot), out_valid ? (1 << out) : 0);
`endif
    endtask

    // Drive one vector, clock it, then check 1 time unit after the edge.
    task automatic step(input logic [WIDTH-1:0] v, input logic e, input string tag);
        in = v;
        en = e;
        @(posedge clk);
        if (e) model(int'(v));
        #1;
        chk_all(tag);
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b1;
        in    = 8'hFF;
        #1 rst_n = 1'b0;
        #1;
        exp_out = 0; exp_valid = 0; exp_oh = 0;
        chk_all("rst_async");
        repeat (2) @(posedge clk);
        #1 chk_all("rst_held");

        @(negedge clk) rst_n = 1'b1;
        step(8'hFF, 1'b1, "rst_release");
        chk("rst_release.idx7", int'(out), 7);

        step(8'h24, 1'b1, "p24");
        chk("p24.idx", int'(out), 5);
        step(8'h01, 1'b1, "p01");
        chk("p01.valid", int'(out_valid), 1);
        step(8'h80, 1'b1, "p80");
        step(8'h12, 1'b1, "p12");
        chk("p12.idx", int'(out), 4);
        step(8'h81, 1'b1, "p81");
        step(8'h00, 1'b1, "zero");
        chk("zero.valid", int'(out_valid), 0);

        step(8'h40, 1'b1, "hold_cap");
        chk("hold_cap.idx", int'(out), 6);
        for (int i = 0; i < 3; i++) step(8'h03, 1'b0, "hold");
        chk("hold.idx", int'(out), 6);
        step(8'h03, 1'b1, "hold_rel");
        chk("hold_rel.idx", int'(out), 1);

        step(8'h24, 1'b1, "mid_pre");
        #2 rst_n = 1'b0;
        in = 8'h80;
        #1;
        exp_out = 0; exp_valid = 0; exp_oh = 0;
        chk_all("mid_rst");
        @(posedge clk);
        #1 chk_all("mid_rst_edge");
        @(negedge clk) rst_n = 1'b1;
        step(8'h80, 1'b0, "mid_rel_noen");
        step(8'h80, 1'b1, "mid_rel_en");
        chk("mid_rel_en.idx", int'(out), 7);

`ifdef PRIORITY_ENCODER_ONEHOT_EN
        step(8'b0110_1010, 1'b1, "oh6a");
        chk("oh6a.onehot", int'(out_onehot), 8'b0100_0000);
        chk("oh6a.idx", int'(out), 6);
`endif

        for (int i = 0; i < 1000; i++) begin
            logic [WIDTH-1:0] v;
            v = WIDTH'($urandom);
            if ($urandom_range(0, 15) == 0) v = '0;
            else if ($urandom_range(0, 3) == 0) v = v >> $urandom_range(0, 7);
            step(v, ($urandom_range(0, 3) != 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
